// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the RV32I pipeline controller:
// FSM state encoding, forwarding select codes and a register-match helper.
package pipe_ctrl_pkg;

    typedef logic [0:0] state_t;

    localparam state_t RUN  = 1'b0;
    localparam state_t WAIT = 1'b1;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_WB    = 2'b10;

    // A producer only counts if it really writes and is not targeting x0.
    function automatic logic reg_hit(input logic [4:0] rd, input logic we, input logic [4:0] rs);
        return we && (rd != 5'd0) && (rd == rs);
    endfunction

endpackage

// File: rtl/fwd_unit.sv
// Single-operand EX-stage forwarding select; the MEM-stage producer is
// younger than the WB-stage producer, so it takes precedence.
module fwd_unit
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] rs_i,
    input  logic [4:0] rd_mem_i,
    input  logic       RegWEn_mem_i,
    input  logic [4:0] rd_wb_i,
    input  logic       RegWEn_wb_i,
    output logic [1:0] sel_o
);

    always_comb begin
        sel_o = FWD_RF;
        if (reg_hit(rd_mem_i, RegWEn_mem_i, rs_i)) begin
            sel_o = FWD_EXMEM;
        end else if (reg_hit(rd_wb_i, RegWEn_wb_i, rs_i)) begin
            sel_o = FWD_WB;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central hazard controller: forwarding selects, load-use bubbles, branch
// flushes, data-memory wait sequencing with timeout, and perf counters.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [4:0]  rs1_id_i,
    input  logic [4:0]  rs2_id_i,
    input  logic [4:0]  rs1_ex_i,
    input  logic [4:0]  rs2_ex_i,
    input  logic [4:0]  rd_ex_i,
    input  logic        RegWEn_ex_i,
    input  logic        load_ex_i,
    input  logic [4:0]  rd_mem_i,
    input  logic        RegWEn_mem_i,
    input  logic [4:0]  rd_wb_i,
    input  logic        RegWEn_wb_i,
    input  logic        br_taken_ex_i,
    input  logic        mem_access_mem_i,
    input  logic        dmem_ack_i,
    output logic [1:0]  Asel_haz_o,
    output logic [1:0]  Bsel_haz_o,
    output logic        en_pc_o,
    output logic        en_ifid_o,
    output logic        en_idex_o,
    output logic        en_exmem_o,
    output logic        en_memwb_o,
    output logic        clr_ifid_o,
    output logic        clr_idex_o,
    output logic        dmem_req_o,
    output logic        bus_err_o,
    output logic [31:0] stall_cnt_o,
    output logic [31:0] flush_cnt_o
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic               freeze;
    logic               load_use;
    logic               timeout;

    fwd_unit u_fwd_a (
        .rs_i         (rs1_ex_i),
        .rd_mem_i     (rd_mem_i),
        .RegWEn_mem_i (RegWEn_mem_i),
        .rd_wb_i      (rd_wb_i),
        .RegWEn_wb_i  (RegWEn_wb_i),
        .sel_o        (Asel_haz_o)
    );

    fwd_unit u_fwd_b (
        .rs_i         (rs2_ex_i),
        .rd_mem_i     (rd_mem_i),
        .RegWEn_mem_i (RegWEn_mem_i),
        .rd_wb_i      (rd_wb_i),
        .RegWEn_wb_i  (RegWEn_wb_i),
        .sel_o        (Bsel_haz_o)
    );

    assign load_use = load_ex_i &&
                      (reg_hit(rd_ex_i, RegWEn_ex_i, rs1_id_i) ||
                       reg_hit(rd_ex_i, RegWEn_ex_i, rs2_id_i));

    assign timeout = (wait_cnt_q == CNT_W'(MEM_TIMEOUT));

    // A cycle that releases from WAIT (ack or timeout) falls through to the
    // normal branch/load-use rules, so hazards held during the freeze resolve then.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        freeze     = 1'b0;
        bus_err_o  = 1'b0;
        dmem_req_o = mem_access_mem_i;

        if (state_q == RUN) begin
            if (mem_access_mem_i && !dmem_ack_i) begin
                freeze     = 1'b1;
                state_d    = WAIT;
                wait_cnt_d = CNT_W'(1);
            end
        end else begin
            dmem_req_o = 1'b1;
            if (dmem_ack_i) begin
                state_d    = RUN;
                wait_cnt_d = '0;
            end else if (timeout) begin
                bus_err_o  = 1'b1;
                state_d    = RUN;
                wait_cnt_d = '0;
            end else begin
                freeze     = 1'b1;
                wait_cnt_d = wait_cnt_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        en_pc_o    = 1'b1;
        en_ifid_o  = 1'b1;
        en_idex_o  = 1'b1;
        en_exmem_o = 1'b1;
        en_memwb_o = 1'b1;
        clr_ifid_o = 1'b0;
        clr_idex_o = 1'b0;
        if (freeze) begin
            en_pc_o    = 1'b0;
            en_ifid_o  = 1'b0;
            en_idex_o  = 1'b0;
            en_exmem_o = 1'b0;
            en_memwb_o = 1'b0;
        end else if (br_taken_ex_i) begin
            clr_ifid_o = 1'b1;
            clr_idex_o = 1'b1;
        end else if (load_use) begin
            en_pc_o    = 1'b0;
            en_ifid_o  = 1'b0;
            clr_idex_o = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= RUN;
            wait_cnt_q  <= '0;
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            if (!en_pc_o) begin
                stall_cnt_o <= stall_cnt_o + 32'd1;
            end
            if (clr_ifid_o) begin
                flush_cnt_o <= flush_cnt_o + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl with a short memory
// timeout so the timeout path is reached quickly.
module tb_pipe_hazard_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [4:0]  rs1_id_i, rs2_id_i, rs1_ex_i, rs2_ex_i;
    logic [4:0]  rd_ex_i, rd_mem_i, rd_wb_i;
    logic        RegWEn_ex_i, load_ex_i, RegWEn_mem_i, RegWEn_wb_i;
    logic        br_taken_ex_i, mem_access_mem_i, dmem_ack_i;
    logic [1:0]  Asel_haz_o, Bsel_haz_o;
    logic        en_pc_o, en_ifid_o, en_idex_o, en_exmem_o, en_memwb_o;
    logic        clr_ifid_o, clr_idex_o, dmem_req_o, bus_err_o;
    logic [31:0] stall_cnt_o, flush_cnt_o;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .rs1_id_i         (rs1_id_i),
        .rs2_id_i         (rs2_id_i),
        .rs1_ex_i         (rs1_ex_i),
        .rs2_ex_i         (rs2_ex_i),
        .rd_ex_i          (rd_ex_i),
        .RegWEn_ex_i      (RegWEn_ex_i),
        .load_ex_i        (load_ex_i),
        .rd_mem_i         (rd_mem_i),
        .RegWEn_mem_i     (RegWEn_mem_i),
        .rd_wb_i          (rd_wb_i),
        .RegWEn_wb_i      (RegWEn_wb_i),
        .br_taken_ex_i    (br_taken_ex_i),
        .mem_access_mem_i (mem_access_mem_i),
        .dmem_ack_i       (dmem_ack_i),
        .Asel_haz_o       (Asel_haz_o),
        .Bsel_haz_o       (Bsel_haz_o),
        .en_pc_o          (en_pc_o),
        .en_ifid_o        (en_ifid_o),
        .en_idex_o        (en_idex_o),
        .en_exmem_o       (en_exmem_o),
        .en_memwb_o       (en_memwb_o),
        .clr_ifid_o       (clr_ifid_o),
        .clr_idex_o       (clr_idex_o),
        .dmem_req_o       (dmem_req_o),
        .bus_err_o        (bus_err_o),
        .stall_cnt_o      (stall_cnt_o),
        .flush_cnt_o      (flush_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        rs1_id_i = 0; rs2_id_i = 0; rs1_ex_i = 0; rs2_ex_i = 0;
        rd_ex_i = 0; rd_mem_i = 0; rd_wb_i = 0;
        RegWEn_ex_i = 0; load_ex_i = 0; RegWEn_mem_i = 0; RegWEn_wb_i = 0;
        br_taken_ex_i = 0; mem_access_mem_i = 0; dmem_ack_i = 0;
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [4:0] enables();
        return {en_pc_o, en_ifid_o, en_idex_o, en_exmem_o, en_memwb_o};
    endfunction

    initial begin
        rst_ni = 1'b0;
        clear_inputs();
        #2;
        check_output("rst_sel",   {Asel_haz_o, Bsel_haz_o}, 4'b0000);
        check_output("rst_en",    enables(), 5'b11111);
        check_output("rst_clr",   {clr_ifid_o, clr_idex_o}, 2'b00);
        check_output("rst_req",   dmem_req_o, 1'b0);
        check_output("rst_err",   bus_err_o, 1'b0);
        check_output("rst_stall", stall_cnt_o, 32'd0);
        check_output("rst_flush", flush_cnt_o, 32'd0);
        #10 rst_ni = 1'b1;
        tick();

        // Forwarding: MEM beats WB, x0 never forwarded, WB-only match.
        rd_mem_i = 5; RegWEn_mem_i = 1; rd_wb_i = 5; RegWEn_wb_i = 1; rs1_ex_i = 5;
        #1 check_output("fwd_mem_over_wb", {Asel_haz_o, Bsel_haz_o}, 4'b0100);
        rd_mem_i = 0; rd_wb_i = 0; rs1_ex_i = 0; rs2_ex_i = 0;
        #1 check_output("fwd_x0", {Asel_haz_o, Bsel_haz_o}, 4'b0000);
        rd_mem_i = 3; rd_wb_i = 9; rs1_ex_i = 3; rs2_ex_i = 9;
        #1 check_output("fwd_mem_wb_split", {Asel_haz_o, Bsel_haz_o}, 4'b0110);
        RegWEn_mem_i = 0; rd_mem_i = 9; rs1_ex_i = 9; rs2_ex_i = 4;
        #1 check_output("fwd_wb_only", {Asel_haz_o, Bsel_haz_o}, 4'b1000);

        // Load-use on rs2: one bubble, then the consumer forwards from WB.
        tick();
        clear_inputs();
        load_ex_i = 1; RegWEn_ex_i = 1; rd_ex_i = 7; rs2_id_i = 7;
        #1 check_output("lu_en",  enables(), 5'b00111);
        check_output("lu_clr", {clr_ifid_o, clr_idex_o}, 2'b01);
        tick();
        check_output("lu_stall_cnt", stall_cnt_o, 32'd1);
        clear_inputs();
        rs2_ex_i = 7; rd_wb_i = 7; RegWEn_wb_i = 1;
        #1 check_output("lu_fwd_wb", Bsel_haz_o, 2'b10);
        check_output("lu_after_en", enables(), 5'b11111);

        // Branch together with load-use: flush only.
        tick();
        clear_inputs();
        br_taken_ex_i = 1; load_ex_i = 1; RegWEn_ex_i = 1; rd_ex_i = 7; rs1_id_i = 7;
        #1 check_output("br_en",  enables(), 5'b11111);
        check_output("br_clr", {clr_ifid_o, clr_idex_o}, 2'b11);
        tick();
        check_output("br_flush_cnt", flush_cnt_o, 32'd1);
        check_output("br_stall_cnt", stall_cnt_o, 32'd1);

        // Store with ack on the 3rd WAIT cycle: 3 frozen cycles, 4 request cycles.
        clear_inputs();
        mem_access_mem_i = 1;
        #1 check_output("mw0_req", dmem_req_o, 1'b1);
        check_output("mw0_en",  enables(), 5'b00000);
        check_output("mw0_clr", {clr_ifid_o, clr_idex_o}, 2'b00);
        tick();
        check_output("mw1_req", dmem_req_o, 1'b1);
        check_output("mw1_en",  enables(), 5'b00000);
        tick();
        check_output("mw2_en",  enables(), 5'b00000);
        check_output("mw2_err", bus_err_o, 1'b0);
        tick();
        dmem_ack_i = 1;
        #1 check_output("mw3_req", dmem_req_o, 1'b1);
        check_output("mw3_en",  enables(), 5'b11111);
        check_output("mw3_err", bus_err_o, 1'b0);
        tick();
        clear_inputs();
        #1 check_output("mw4_req", dmem_req_o, 1'b0);
        check_output("mw4_en",  enables(), 5'b11111);
        check_output("mw_stall_cnt", stall_cnt_o, 32'd4);

        // Timeout with a branch held during the freeze.
        mem_access_mem_i = 1; br_taken_ex_i = 1;
        #1 check_output("to0_en",  enables(), 5'b00000);
        check_output("to0_clr", {clr_ifid_o, clr_idex_o}, 2'b00);
        for (int i = 1; i <= 3; i++) begin
            tick();
            check_output($sformatf("to%0d_err", i), bus_err_o, 1'b0);
            check_output($sformatf("to%0d_en", i),  enables(), 5'b00000);
        end
        tick();
        check_output("to4_err", bus_err_o, 1'b1);
        check_output("to4_en",  enables(), 5'b11111);
        check_output("to4_clr", {clr_ifid_o, clr_idex_o}, 2'b11);
        tick();
        clear_inputs();
        #1 check_output("to5_err", bus_err_o, 1'b0);
        check_output("to5_req", dmem_req_o, 1'b0);
        check_output("to_stall_cnt", stall_cnt_o, 32'd8);
        check_output("to_flush_cnt", flush_cnt_o, 32'd2);

        // Reset asserted while in WAIT.
        mem_access_mem_i = 1;
        tick();
        check_output("rw_wait_en", enables(), 5'b00000);
        rst_ni = 1'b0;
        #1 check_output("rw_stall_cnt", stall_cnt_o, 32'd0);
        check_output("rw_flush_cnt", flush_cnt_o, 32'd0);
        check_output("rw_err", bus_err_o, 1'b0);
        check_output("rw_req_follow", dmem_req_o, 1'b1);
        mem_access_mem_i = 0;
        #1 check_output("rw_req_idle", dmem_req_o, 1'b0);
        check_output("rw_en", enables(), 5'b11111);
        #2 rst_ni = 1'b1;
        tick();
        check_output("rw_post_en", enables(), 5'b11111);
        check_output("rw_post_stall", stall_cnt_o, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
